counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of DOUT, LOAD_VAL, LIMIT.
REQ-002 CLK_1Hz input 1: sole clock; all state updates occur on its rising edge.
REQ-003 RST input 1: reset, asynchronous, active-low.
REQ-004 START input 1: begin or resume counting; level sampled per clock.
REQ-005 STOP input 1: pause counting.
REQ-006 CLR input 1: synchronous clear to IDLE with count zero.
REQ-007 LOAD input 1: load LOAD_VAL into count and reload register.
REQ-008 LOAD_VAL input WIDTH: value captured on LOAD.
REQ-009 LIMIT input WIDTH: terminal count compare value.
REQ-010 UP_DN input 1: 1 = increment, 0 = decrement.
REQ-011 DOUT output WIDTH: current count, registered.
REQ-012 STATE output 2: IDLE=00, RUN=01, PAUSE=10, DONE=11, registered.
REQ-013 BUSY output 1: 1 when STATE is RUN or PAUSE.
REQ-014 DONE output 1: 1 when STATE is DONE.
REQ-015 WRAP output 1: one-cycle pulse on auto-reload (see Configuration).

Function
REQ-016 Command priority per cycle SHALL be CLR > LOAD > STOP > START; lower-priority commands asserted in the same cycle are ignored.
REQ-017 CLR in any state: DOUT<=0, STATE<=IDLE; reload register unchanged.
REQ-018 LOAD in any state: DOUT<=LOAD_VAL, reload register<=LOAD_VAL, STATE<=IDLE.
REQ-019 IDLE + START: STATE<=RUN, DOUT unchanged; STOP ignored.
REQ-020 RUN, no command, DOUT!=LIMIT: DOUT<=DOUT+1 (UP_DN=1) or DOUT-1 (UP_DN=0), modulo 2^WIDTH (15->0 up, 0->15 down).
REQ-021 RUN, no command, DOUT==LIMIT: terminal event; DOUT held, STATE<=DONE (base build).
REQ-022 RUN + STOP: STATE<=PAUSE, DOUT held; START in RUN has no effect.
REQ-023 PAUSE + START: STATE<=RUN, DOUT held; counting resumes the following cycle; STOP in PAUSE ignored.
REQ-024 DONE + START: DOUT<=reload register, STATE<=RUN; STOP ignored; DONE held otherwise.
REQ-025 Latency: START sampled at edge n gives STATE=RUN after edge n; first count change after edge n+1.
REQ-026 UP_DN SHALL be sampled each RUN cycle; a change mid-run takes effect on the next step.
REQ-027 If DOUT already equals LIMIT when RUN is entered, terminal event occurs on the first RUN cycle with no count step.
REQ-028 BUSY, DONE SHALL be decoded from the registered STATE, glitch-free, same cycle as STATE.

Reset
REQ-029 RST low SHALL immediately force DOUT=0, reload register=0, STATE=IDLE, WRAP=0, independent of CLK_1Hz, including mid-RUN or mid-PAUSE.
REQ-030 After RST deasserts, first state change occurs only on a CLK_1Hz rising edge with a valid command.

Configuration
REQ-031 Macro COUNTER_CTRL_AUTORELOAD_EN defined: on RUN terminal event DOUT<=reload register, STATE stays RUN, WRAP=1 for exactly that one cycle; DONE state is never entered from RUN.
REQ-032 Macro undefined: REQ-021 applies; WRAP SHALL be constant 0.

Verification
REQ-033 RST low, LOAD 3, LIMIT=6, UP_DN=1, START -> DOUT 3,3,4,5,6 then STATE=DONE, DONE=1, DOUT=6 held.
REQ-034 LOAD 1, LIMIT=14, UP_DN=0, START -> DOUT 1,0,15,14 then DONE; wrap 0->15 verified.
REQ-035 Running at DOUT=5, STOP for 3 cycles -> STATE=PAUSE, DOUT=5 held; START -> RUN, next step DOUT=6.
REQ-036 CLR, LOAD, STOP, START all asserted together in RUN -> DOUT=0, STATE=IDLE; LOAD+START together -> DOUT=LOAD_VAL, STATE=IDLE.
REQ-037 RST pulsed low between clock edges mid-RUN at DOUT=9 -> DOUT=0, STATE=IDLE immediately, before next edge.
REQ-038 COUNTER_CTRL_AUTORELOAD_EN build, LOAD 2, LIMIT=4, UP, START -> DOUT 2,2,3,4,2,3,4..., WRAP=1 one cycle at each 4->2, DONE never 1.

Source files
------------

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//
// Command-driven up/down counter with a four-state control FSM
// (IDLE / RUN / PAUSE / DONE) and a reload register.
//
// Per clock, commands are resolved in the order CLR > LOAD > STOP > START.
// While in RUN the count steps by one per clock, in the direction chosen by
// UP_DN, until it matches LIMIT.
//
// Configuration macro: COUNTER_CTRL_AUTORELOAD_EN
//   undefined (default) : reaching LIMIT in RUN moves the FSM to DONE and
//                         WRAP is tied low.
//   defined             : reaching LIMIT in RUN reloads the count from the
//                         reload register, the FSM stays in RUN, and WRAP
//                         pulses for that one cycle.
//
// Ports
//   CLK_1Hz   in   1      sole clock, rising edge
//   RST       in   1      asynchronous reset, active low
//   START     in   1      begin / resume counting
//   STOP      in   1      pause counting
//   CLR       in   1      synchronous clear to IDLE with count zero
//   LOAD      in   1      load LOAD_VAL into the count and reload register
//   LOAD_VAL  in   WIDTH  value captured on LOAD
//   LIMIT     in   WIDTH  terminal count compare value
//   UP_DN     in   1      1 = increment, 0 = decrement
//   DOUT      out  WIDTH  current count (registered)
//   STATE     out  2      IDLE=00 RUN=01 PAUSE=10 DONE=11 (registered)
//   BUSY      out  1      STATE is RUN or PAUSE
//   DONE      out  1      STATE is DONE
//   WRAP      out  1      one-cycle pulse on auto-reload
// ---------------------------------------------------------------------------
module counter_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             CLK_1Hz,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             UP_DN,
   output logic [WIDTH-1:0] DOUT,
   output logic [1:0]       STATE,
   output logic             BUSY,
   output logic             DONE,
   output logic             WRAP
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic [WIDTH-1:0] count_step;

`ifdef COUNTER_CTRL_AUTORELOAD_EN
   logic             wrap_q;
   logic             wrap_d;
`endif

   // Next count value while running; modulo 2^WIDTH in both directions.
   assign count_step = UP_DN ? (DOUT + ONE) : (DOUT - ONE);

   // -----------------------------------------------------------------------
   // State register (count and reload register live here too so that the
   // asynchronous reset clears everything at once).
   // -----------------------------------------------------------------------
   always_ff @(posedge CLK_1Hz or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         DOUT     <= '0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         DOUT     <= count_d;
         reload_q <= reload_d;
      end
   end

`ifdef COUNTER_CTRL_AUTORELOAD_EN
   always_ff @(posedge CLK_1Hz or negedge RST) begin
      if (!RST) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign WRAP = wrap_q;
`else
   assign WRAP = 1'b0;
`endif

   // -----------------------------------------------------------------------
   // Next-state logic. CLR and LOAD act in every state; STOP and START are
   // only meaningful in particular states, and STOP shadows START.
   // -----------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      count_d  = DOUT;
      reload_d = reload_q;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
      wrap_d   = 1'b0;
`endif

      if (CLR) begin
         // Reload register is deliberately kept across a clear.
         state_d = S_IDLE;
         count_d = '0;
      end else if (LOAD) begin
         state_d  = S_IDLE;
         count_d  = LOAD_VAL;
         reload_d = LOAD_VAL;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!STOP && START) begin
                  state_d = S_RUN;
               end
            end

            S_RUN: begin
               if (STOP) begin
                  state_d = S_PAUSE;
               end else if (DOUT == LIMIT) begin
                  // Terminal event; checked before stepping so that entering
                  // RUN already at LIMIT terminates without a count step.
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                  count_d = reload_q;
                  wrap_d  = 1'b1;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  count_d = count_step;
               end
            end

            S_PAUSE: begin
               if (!STOP && START) begin
                  state_d = S_RUN;
               end
            end

            S_DONE: begin
               if (!STOP && START) begin
                  state_d = S_RUN;
                  count_d = reload_q;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Output decode, purely from the registered state so the flags change in
   // the same cycle as STATE and cannot glitch on input activity.
   // -----------------------------------------------------------------------
   always_comb begin
      STATE = state_q;
      BUSY  = (state_q == S_RUN) || (state_q == S_PAUSE);
      DONE  = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
//
// Directed bench for counter_ctrl. The driver applies one command vector per
// clock on the falling edge and queues the hand-computed register contents
// expected after the following rising edge; the monitor pops and compares
// just after each rising edge. Asynchronous-reset behaviour is checked
// directly between edges. Expected values follow the build selected by
// COUNTER_CTRL_AUTORELOAD_EN.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] PAU  = 2'b10;
   localparam logic [1:0] DN   = 2'b11;

   // command vector bits: {CLR, LOAD, STOP, START}
   localparam logic [3:0] C_NONE  = 4'b0000;
   localparam logic [3:0] C_START = 4'b0001;
   localparam logic [3:0] C_STOP  = 4'b0010;
   localparam logic [3:0] C_LOAD  = 4'b0100;
   localparam logic [3:0] C_CLR   = 4'b1000;

   logic       clk;
   logic       rst;
   logic       start, stop, clr, load, up_dn;
   logic [3:0] load_val, limit;
   logic [3:0] dout;
   logic [1:0] state;
   logic       busy, done, wrap;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] d;
      logic [1:0] s;
      logic       w;
   } exp_t;

   exp_t sb[$];

   counter_ctrl #(.WIDTH(4)) dut (
      .CLK_1Hz  (clk),
      .RST      (rst),
      .START    (start),
      .STOP     (stop),
      .CLR      (clr),
      .LOAD     (load),
      .LOAD_VAL (load_val),
      .LIMIT    (limit),
      .UP_DN    (up_dn),
      .DOUT     (dout),
      .STATE    (state),
      .BUSY     (busy),
      .DONE     (done),
      .WRAP     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] d, input logic [1:0] s,
                          input logic w);
      chk({tag, " DOUT"},  32'(dout),  32'(d));
      chk({tag, " STATE"}, 32'(state), 32'(s));
      chk({tag, " BUSY"},  32'(busy),  32'((s == RUN) || (s == PAU)));
      chk({tag, " DONE"},  32'(done),  32'(s == DN));
      chk({tag, " WRAP"},  32'(wrap),  32'(w));
   endtask

   // Drive one vector and queue the expected result of the next rising edge.
   task automatic step(input string tag, input logic [3:0] cmd, input logic [3:0] lv,
                       input logic [3:0] lim, input logic up,
                       input logic [3:0] ed, input logic [1:0] es, input logic ew);
      exp_t e;
      @(negedge clk);
      {clr, load, stop, start} = cmd;
      load_val = lv;
      limit    = lim;
      up_dn    = up;
      e.tag = tag;
      e.d   = ed;
      e.s   = es;
      e.w   = ew;
      sb.push_back(e);
   endtask

   // Monitor: outputs are registered and updated every edge, so each rising
   // edge presents one result to compare.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_all(e.tag, e.d, e.s, e.w);
      end
   end

   initial begin
      rst = 1'b1;
      {clr, load, stop, start} = 4'b0000;
      load_val = '0;
      limit    = '0;
      up_dn    = 1'b1;

      // Reset asserted before any clock edge, then held across edges.
      #2 rst = 1'b0;
      #1 chk_all("reset_async", 4'd0, IDLE, 1'b0);
      repeat (2) @(posedge clk);
      #1 chk_all("reset_held", 4'd0, IDLE, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // No command after reset: nothing moves.
      step("post_reset_idle", C_NONE, 4'd0, 4'd6, 1'b1, 4'd0, IDLE, 1'b0);

`ifdef COUNTER_CTRL_AUTORELOAD_EN
      // LOAD 2, LIMIT 4, up: 2,2,3,4,2,3,4,2 with WRAP on each 4->2.
      step("ar_load",  C_LOAD,  4'd2, 4'd4, 1'b1, 4'd2, IDLE, 1'b0);
      step("ar_start", C_START, 4'd0, 4'd4, 1'b1, 4'd2, RUN,  1'b0);
      step("ar_c3",    C_NONE,  4'd0, 4'd4, 1'b1, 4'd3, RUN,  1'b0);
      step("ar_c4",    C_NONE,  4'd0, 4'd4, 1'b1, 4'd4, RUN,  1'b0);
      step("ar_wrap1", C_NONE,  4'd0, 4'd4, 1'b1, 4'd2, RUN,  1'b1);
      step("ar_c3b",   C_NONE,  4'd0, 4'd4, 1'b1, 4'd3, RUN,  1'b0);
      step("ar_c4b",   C_NONE,  4'd0, 4'd4, 1'b1, 4'd4, RUN,  1'b0);
      step("ar_wrap2", C_NONE,  4'd0, 4'd4, 1'b1, 4'd2, RUN,  1'b1);
      step("ar_c3c",   C_NONE,  4'd0, 4'd4, 1'b1, 4'd3, RUN,  1'b0);
      step("ar_clr",   C_CLR,   4'd0, 4'd4, 1'b1, 4'd0, IDLE, 1'b0);
`else
      // LOAD 3, LIMIT 6, up: 3,3,4,5,6 then DONE with 6 held.
      step("up_load",  C_LOAD,  4'd3, 4'd6, 1'b1, 4'd3, IDLE, 1'b0);
      step("up_start", C_START, 4'd0, 4'd6, 1'b1, 4'd3, RUN,  1'b0);
      step("up_c4",    C_NONE,  4'd0, 4'd6, 1'b1, 4'd4, RUN,  1'b0);
      step("up_c5",    C_NONE,  4'd0, 4'd6, 1'b1, 4'd5, RUN,  1'b0);
      step("up_c6",    C_NONE,  4'd0, 4'd6, 1'b1, 4'd6, RUN,  1'b0);
      step("up_done",  C_NONE,  4'd0, 4'd6, 1'b1, 4'd6, DN,   1'b0);
      step("up_hold",  C_NONE,  4'd0, 4'd6, 1'b1, 4'd6, DN,   1'b0);
      step("done_stop",C_STOP,  4'd0, 4'd6, 1'b1, 4'd6, DN,   1'b0);
      step("done_rst", C_START, 4'd0, 4'd6, 1'b1, 4'd3, RUN,  1'b0);
      step("done_run", C_NONE,  4'd0, 4'd6, 1'b1, 4'd4, RUN,  1'b0);

      // LOAD 1, LIMIT 14, down: 1,0,15,14 then DONE.
      step("dn_load",  C_LOAD,  4'd1, 4'd14, 1'b0, 4'd1,  IDLE, 1'b0);
      step("dn_start", C_START, 4'd0, 4'd14, 1'b0, 4'd1,  RUN,  1'b0);
      step("dn_c0",    C_NONE,  4'd0, 4'd14, 1'b0, 4'd0,  RUN,  1'b0);
      step("dn_c15",   C_NONE,  4'd0, 4'd14, 1'b0, 4'd15, RUN,  1'b0);
      step("dn_c14",   C_NONE,  4'd0, 4'd14, 1'b0, 4'd14, RUN,  1'b0);
      step("dn_done",  C_NONE,  4'd0, 4'd14, 1'b0, 4'd14, DN,   1'b0);

      // Already at LIMIT on entering RUN: terminates without stepping.
      step("eq_load",  C_LOAD,  4'd9, 4'd9, 1'b1, 4'd9, IDLE, 1'b0);
      step("eq_start", C_START, 4'd0, 4'd9, 1'b1, 4'd9, RUN,  1'b0);
      step("eq_done",  C_NONE,  4'd0, 4'd9, 1'b1, 4'd9, DN,   1'b0);

      // CLR keeps the reload register: DONE+START afterwards restores 9.
      step("rc_clr",   C_CLR,   4'd0, 4'd0, 1'b1, 4'd0, IDLE, 1'b0);
      step("rc_start", C_START, 4'd0, 4'd0, 1'b1, 4'd0, RUN,  1'b0);
      step("rc_done",  C_NONE,  4'd0, 4'd0, 1'b1, 4'd0, DN,   1'b0);
      step("rc_reload",C_START, 4'd0, 4'd0, 1'b1, 4'd9, RUN,  1'b0);
`endif

      // Pause / resume at 5 with LIMIT out of reach; UP_DN change mid-run.
      step("pr_load",  C_LOAD,  4'd3, 4'd15, 1'b1, 4'd3, IDLE, 1'b0);
      step("pr_start", C_START, 4'd0, 4'd15, 1'b1, 4'd3, RUN,  1'b0);
      step("pr_c4",    C_NONE,  4'd0, 4'd15, 1'b1, 4'd4, RUN,  1'b0);
      step("pr_c5",    C_NONE,  4'd0, 4'd15, 1'b1, 4'd5, RUN,  1'b0);
      step("pr_stop1", C_STOP,  4'd0, 4'd15, 1'b1, 4'd5, PAU,  1'b0);
      step("pr_stop2", C_STOP,  4'd0, 4'd15, 1'b1, 4'd5, PAU,  1'b0);
      step("pr_stop3", C_STOP,  4'd0, 4'd15, 1'b1, 4'd5, PAU,  1'b0);
      step("pr_resume",C_START, 4'd0, 4'd15, 1'b1, 4'd5, RUN,  1'b0);
      step("pr_c6",    C_NONE,  4'd0, 4'd15, 1'b1, 4'd6, RUN,  1'b0);
      step("run_start",C_START, 4'd0, 4'd15, 1'b1, 4'd7, RUN,  1'b0);
      step("dir_down", C_NONE,  4'd0, 4'd15, 1'b0, 4'd6, RUN,  1'b0);

      // Priority: all four together clears; LOAD+START loads and idles.
      step("pri_all",  4'b1111, 4'd9, 4'd15, 1'b1, 4'd0, IDLE, 1'b0);
      step("pri_ldst", 4'b0101, 4'd9, 4'd15, 1'b1, 4'd9, IDLE, 1'b0);

      // Up wrap 15 -> 0.
      step("uw_load",  C_LOAD,  4'd14, 4'd3, 1'b1, 4'd14, IDLE, 1'b0);
      step("uw_start", C_START, 4'd0,  4'd3, 1'b1, 4'd14, RUN,  1'b0);
      step("uw_c15",   C_NONE,  4'd0,  4'd3, 1'b1, 4'd15, RUN,  1'b0);
      step("uw_c0",    C_NONE,  4'd0,  4'd3, 1'b1, 4'd0,  RUN,  1'b0);
      step("uw_c1",    C_NONE,  4'd0,  4'd3, 1'b1, 4'd1,  RUN,  1'b0);

      // Reach 9 in RUN, then pulse reset between edges.
      step("ar_ld8",   C_LOAD,  4'd8, 4'd15, 1'b1, 4'd8, IDLE, 1'b0);
      step("ar_st8",   C_START, 4'd0, 4'd15, 1'b1, 4'd8, RUN,  1'b0);
      step("ar_c9",    C_NONE,  4'd0, 4'd15, 1'b1, 4'd9, RUN,  1'b0);
      {clr, load, stop, start} = C_NONE;
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_all("rst_midrun", 4'd0, IDLE, 1'b0);
      #1 rst = 1'b1;

      // After reset the reload register is 0; LIMIT 0 gives the terminal
      // event straight away.
      step("pr_idle",  C_NONE,  4'd0, 4'd0, 1'b1, 4'd0, IDLE, 1'b0);
      step("pr_run",   C_START, 4'd0, 4'd0, 1'b1, 4'd0, RUN,  1'b0);
`ifdef COUNTER_CTRL_AUTORELOAD_EN
      step("pr_term",  C_NONE,  4'd0, 4'd0, 1'b1, 4'd0, RUN,  1'b1);
`else
      step("pr_term",  C_NONE,  4'd0, 4'd0, 1'b1, 4'd0, DN,   1'b0);
`endif
      step("pr_clr",   C_CLR,   4'd0, 4'd0, 1'b1, 4'd0, IDLE, 1'b0);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
